// File: rtl/slowfil_pkg.sv
// Shared default sizing for the slow-filter output buffer and its FIFO.
package slowfil_pkg;

    localparam int DEF_IW     = 39;
    localparam int DEF_OW     = 16;
    localparam int DEF_SHIFT  = 16;
    localparam int DEF_LGFIFO = 3;

    // A FIFO entry carries the saturation flag above the sample.
    localparam int ENTRY_W    = DEF_OW + 1;

endpackage

// File: rtl/slowfil_sfifo.sv
// Synchronous FIFO with an extra pointer MSB to tell full from empty.
// The head is shown combinationally, and it reads as zero while the FIFO is empty.
module slowfil_sfifo
    import slowfil_pkg::*;
#(
    parameter int DW     = ENTRY_W,
    parameter int LGFLEN = DEF_LGFIFO
)(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [DW-1:0]     i_data,
    input  logic              i_rd,
    output logic [DW-1:0]     o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [LGFLEN:0]   o_level
);
    localparam int DEPTH = 1 << LGFLEN;

    logic [DW-1:0]   mem [DEPTH];
    logic [LGFLEN:0] wptr;
    logic [LGFLEN:0] rptr;
    logic            do_rd;
    logic            do_wr;

    assign o_empty = (wptr == rptr);
    assign o_full  = (wptr[LGFLEN] != rptr[LGFLEN]) &&
                     (wptr[LGFLEN-1:0] == rptr[LGFLEN-1:0]);
    assign do_rd   = i_rd && !o_empty;
    // If a pop happens in the same cycle, a write is accepted even when the FIFO is full.
    assign do_wr   = i_wr && (!o_full || do_rd);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr)
                wptr <= wptr + 1'b1;
            if (do_rd)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr)
            mem[wptr[LGFLEN-1:0]] <= i_data;
    end

    assign o_level = wptr - rptr;
    assign o_data  = o_empty ? '0 : mem[rptr[LGFLEN-1:0]];

endmodule

// File: rtl/slowfil_outbuf.sv
// Output stage for the slow filter: shift, saturate, then buffer the samples in a small FIFO.
// Defining SLOWFIL_OUTBUF_ROUND_EN switches stage 1 from truncation to round-half-to-even.
module slowfil_outbuf
    import slowfil_pkg::*;
#(
    parameter int IW     = DEF_IW,
    parameter int OW     = DEF_OW,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int LGFIFO = DEF_LGFIFO
)(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_ce,
    input  logic [IW-1:0]     i_data,
    input  logic              i_clr_ovf,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [OW-1:0]     o_data,
    output logic              o_sat,
    output logic [LGFIFO:0]   o_level,
    output logic              o_overflow
);
    // The extra bit leaves headroom, so the rounding increment cannot wrap.
    localparam int RW = IW - SHIFT + 1;

    if (IW < OW + SHIFT + 1 || LGFIFO < 1) begin : g_bad_params
        $error("slowfil_outbuf: requires IW >= OW+SHIFT+1 and LGFIFO >= 1");
    end

    logic signed [RW-1:0] trunc_val;
    logic signed [RW-1:0] round_val;
    logic signed [RW-1:0] s1_data;
    logic                 s1_valid;
    logic [RW-OW:0]       upper;
    logic [OW-1:0]        sat_data;
    logic                 sat_flag;
    logic [OW-1:0]        s2_data;
    logic                 s2_sat;
    logic                 s2_valid;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 drop;

    assign trunc_val = RW'($signed(i_data) >>> SHIFT);

`ifdef SLOWFIL_OUTBUF_ROUND_EN
    localparam logic [SHIFT-1:0] HALF = SHIFT'(1) << (SHIFT - 1);
    logic round_up;
    assign round_up  = (i_data[SHIFT-1:0] > HALF) ||
                       ((i_data[SHIFT-1:0] == HALF) && trunc_val[0]);
    assign round_val = trunc_val + RW'(round_up);
`else
    assign round_val = trunc_val;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= i_ce;
            if (i_ce)
                s1_data <= round_val;
        end
    end

    // The value fits in OW bits only when every bit from OW-1 upward equals the sign bit.
    assign upper = s1_data[RW-1:OW-1];

    always_comb begin
        sat_data = s1_data[OW-1:0];
        sat_flag = 1'b0;
        if (!(&upper || ~|upper)) begin
            sat_flag = 1'b1;
            sat_data = s1_data[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= sat_data;
                s2_sat  <= sat_flag;
            end
        end
    end

    assign o_valid = !fifo_empty;
    assign pop     = o_valid && i_ready;
    assign drop    = s2_valid && fifo_full && !pop;

    slowfil_sfifo #(
        .DW     (OW + 1),
        .LGFLEN (LGFIFO)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr      (s2_valid),
        .i_data    ({s2_sat, s2_data}),
        .i_rd      (pop),
        .o_data    ({o_sat, o_data}),
        .o_empty   (fifo_empty),
        .o_full    (fifo_full),
        .o_level   (o_level)
    );

    // When a drop and a clear land on the same edge, the drop wins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            o_overflow <= 1'b0;
        else if (drop)
            o_overflow <= 1'b1;
        else if (i_clr_ovf)
            o_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_slowfil_outbuf.sv
// Self-checking bench for slowfil_outbuf: table vectors, corner-case sequences and randomized traffic.
// The expected samples come from a queue-based model of the output stage.
module tb_slowfil_outbuf;

    localparam int IW = 39;
    localparam int OW = 16;
    localparam int LG = 3;
    localparam int DEPTH = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_ce = 1'b0;
    logic [IW-1:0] i_data = '0;
    logic          i_clr_ovf = 1'b0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [OW-1:0] o_data;
    logic          o_sat;
    logic [LG:0]   o_level;
    logic          o_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: the two in-flight samples, the buffered queue and the sticky flag.
    logic        m_p1v, m_p2v;
    logic [16:0] m_p1, m_p2;
    logic [16:0] m_q[$];
    logic        m_ovf;

    typedef struct {
        longint      din;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[5];

    slowfil_outbuf #(.IW(IW), .OW(OW), .SHIFT(16), .LGFIFO(LG)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_ce       (i_ce),
        .i_data     (i_data),
        .i_clr_ovf  (i_clr_ovf),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_sat      (o_sat),
        .o_level    (o_level),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [16:0] ref_sample(input longint d);
        longint v;
        v = d >>> 16;
`ifdef SLOWFIL_OUTBUF_ROUND_EN
        begin
            longint frac;
            frac = d - (v <<< 16);
            if (frac > 32768 || (frac == 32768 && v[0]))
                v = v + 1;
        end
`endif
        if (v > 32767)
            return {1'b1, 16'h7FFF};
        if (v < -32768)
            return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    task automatic model_reset();
        m_p1v = 1'b0;
        m_p2v = 1'b0;
        m_p1  = '0;
        m_p2  = '0;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic ce, input longint d, input logic rdy, input logic clr);
        logic was_full, popped, dropped;
        was_full = (m_q.size() == DEPTH);
        popped   = rdy && (m_q.size() > 0);
        dropped  = 1'b0;
        if (popped)
            void'(m_q.pop_front());
        if (m_p2v) begin
            if (!was_full || popped)
                m_q.push_back(m_p2);
            else
                dropped = 1'b1;
        end
        if (dropped)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
        m_p2v = m_p1v;
        m_p2  = m_p1;
        m_p1v = ce;
        m_p1  = ref_sample(d);
    endtask

    task automatic compare(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [16:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 17'h0;
        n_cmp++;
        if (o_valid !== (m_q.size() > 0) || o_level !== 4'(m_q.size()) ||
            o_data !== head[15:0] || o_sat !== head[16] || o_overflow !== m_ovf) begin
            n_bad++;
            $display("[TB] FAIL %s: got v=%0b lvl=%0d d=0x%h s=%0b ovf=%0b, expected v=%0b lvl=%0d d=0x%h s=%0b ovf=%0b at %0t",
                     tag, o_valid, o_level, o_data, o_sat, o_overflow,
                     m_q.size() > 0, m_q.size(), head[15:0], head[16], m_ovf, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then check just after the edge.
    task automatic applyStimulus(input logic ce, input longint d, input logic rdy, input logic clr);
        longint dn;
        dn = (d <<< 25) >>> 25;
        i_ce      = ce;
        i_data    = dn[IW-1:0];
        i_ready   = rdy;
        i_clr_ovf = clr;
        @(posedge i_clk);
        model_edge(ce, dn, rdy, clr);
        #1;
        checkOutput("cycle");
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        #1;
        compare("async_rst_valid", longint'(o_valid), 0);
        compare("async_rst_level", longint'(o_level), 0);
        model_reset();
        i_ce = 1'b0;
        i_ready = 1'b0;
        i_clr_ovf = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        compare("rst_data", longint'(o_data), 0);
        compare("rst_sat", longint'(o_sat), 0);
        compare("rst_ovf", longint'(o_overflow), 0);
        i_reset_n = 1'b1;
        #1;
    endtask

    initial begin
        int mode;
        longint d;
        logic [15:0] drain_exp[8];

        vecs[0] = '{64'h0000_0001_8000, 16'h0001, 1'b0};
        vecs[1] = '{64'h0000_0002_8000, 16'h0002, 1'b0};
        vecs[2] = '{64'h0000_7FFF_8000, 16'h7FFF, 1'b0};
        vecs[3] = '{-64'sd4294967296,   16'h8000, 1'b1};
        vecs[4] = '{-64'sd65536,        16'hFFFF, 1'b0};
`ifdef SLOWFIL_OUTBUF_ROUND_EN
        vecs[0].exp_data = 16'h0002;
        vecs[2].exp_sat  = 1'b1;
`endif

        $display("[TB] start");
        model_reset();
        #2;
        compare("reset_valid", longint'(o_valid), 0);
        compare("reset_level", longint'(o_level), 0);
        compare("reset_data", longint'(o_data), 0);
        do_reset();

        // Single-sample latency and value checks, with the consumer always ready.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecs[i].din, 1'b1, 1'b0);
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            compare("lat_not_early", longint'(o_valid), 0);
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            compare("lat_valid", longint'(o_valid), 1);
            compare("lat_level", longint'(o_level), 1);
            compare("vec_data", longint'(o_data), longint'(vecs[i].exp_data));
            compare("vec_sat", longint'(o_sat), longint'(vecs[i].exp_sat));
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            compare("lat_one_cycle", longint'(o_valid), 0);
        end

        // Fill past capacity: samples 9 and 10 are dropped.
        for (int k = 1; k <= 10; k++)
            applyStimulus(1'b1, longint'(k) <<< 16, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        compare("fill_level", longint'(o_level), 8);
        compare("fill_ovf", longint'(o_overflow), 1);
        compare("fill_head", longint'(o_data), 1);

        // Write and pop in the same cycle while full: the level stays at 8.
        applyStimulus(1'b1, 64'sd11 <<< 16, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        compare("full_rw_level", longint'(o_level), 8);
        compare("full_rw_ovf", longint'(o_overflow), 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        compare("clr_ovf", longint'(o_overflow), 0);

        drain_exp = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd11};
        for (int i = 0; i < 8; i++) begin
            compare("drain_data", longint'(o_data), longint'(drain_exp[i]));
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
        end
        compare("drained_empty", longint'(o_valid), 0);

        // Reset mid-stream with 5 samples buffered and 2 still in flight.
        for (int k = 1; k <= 7; k++)
            applyStimulus(1'b1, longint'(k + 20) <<< 16, 1'b0, 1'b0);
        compare("pre_rst_level", longint'(o_level), 5);
        do_reset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
        compare("no_stale", longint'(o_valid), 0);
        applyStimulus(1'b1, 64'sd5 <<< 16, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        compare("post_rst_valid", longint'(o_valid), 1);
        compare("post_rst_data", longint'(o_data), 5);

        // Randomized traffic, checked every cycle against the model.
        for (int c = 0; c < 600; c++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: d = longint'({$urandom, $urandom});
                1: d = longint'($signed($urandom));
                2: d = (longint'($signed($urandom_range(0, 65535))) - 32768) * 65536 + 32768;
                default: d = longint'($signed($urandom)) >>> 4;
            endcase
            applyStimulus($urandom_range(0, 3) != 0, d,
                          (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
                          $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
